// File: rtl/logic_shift_unit.sv
// Logic/shift unit: single-cycle logic ops, serial one-bit-per-clock shifts and rotates.
// Results and carry/overflow are registered; sign/zero derive from the held result.
module logic_shift_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       fn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c,
   output logic             v,
   output logic             s,
   output logic             n,
   output logic             z
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] FN_PASS = 3'd0;
   localparam logic [2:0] FN_AND  = 3'd1;
   localparam logic [2:0] FN_OR   = 3'd2;
   localparam logic [2:0] FN_XOR  = 3'd3;
   localparam logic [2:0] FN_SHL  = 3'd4;
   localparam logic [2:0] FN_SHR  = 3'd5;
   localparam logic [2:0] FN_ASR  = 3'd6;
   localparam logic [2:0] FN_ROL  = 3'd7;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] work_q;
   logic [SHW-1:0]   cnt_q;
   logic [2:0]       op_q;
   logic             vacc_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             c_q;
   logic             v_q;

   logic [WIDTH-1:0] logic_res;
   logic [SHW-1:0]   count;
   logic [WIDTH-1:0] work_d;
   logic             vacc_d;
   logic             step_out;

   assign count = b[SHW-1:0];

   always_comb begin
      logic_res = a;
      case (fn)
         FN_PASS: logic_res = a;
         FN_AND:  logic_res = a & b;
         FN_OR:   logic_res = a | b;
         FN_XOR:  logic_res = a ^ b;
         default: logic_res = a;
      endcase
   end

   // One shift/rotate step of the working word; step_out is the bit that leaves it.
   always_comb begin
      work_d   = work_q;
      step_out = 1'b0;
      vacc_d   = vacc_q;
      case (op_q)
         FN_SHL: begin
            work_d   = {work_q[WIDTH-2:0], 1'b0};
            step_out = work_q[WIDTH-1];
            vacc_d   = vacc_q | (work_q[WIDTH-1] ^ work_q[WIDTH-2]);
         end
         FN_SHR: begin
            work_d   = {1'b0, work_q[WIDTH-1:1]};
            step_out = work_q[0];
         end
         FN_ASR: begin
            work_d   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            step_out = work_q[0];
         end
         FN_ROL: begin
            work_d   = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            step_out = work_q[WIDTH-1];
         end
         default: begin
            work_d   = work_q;
            step_out = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         work_q   <= '0;
         cnt_q    <= '0;
         op_q     <= FN_PASS;
         vacc_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (!fn[2] || count == '0) begin
                     result_q <= fn[2] ? a : logic_res;
                     c_q      <= 1'b0;
                     v_q      <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     work_q  <= a;
                     cnt_q   <= count;
                     op_q    <= fn;
                     vacc_q  <= 1'b0;
                     busy_q  <= (count != SHW'(1));
                     state_q <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work_q <= work_d;
               vacc_q <= vacc_d;
               cnt_q  <= cnt_q - SHW'(1);
               // busy covers every shift cycle except the final one
               busy_q <= (cnt_q > SHW'(2));
               if (cnt_q == SHW'(1)) begin
                  result_q <= work_d;
                  c_q      <= step_out;
                  v_q      <= (op_q == FN_SHL) ? vacc_d : 1'b0;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign c      = c_q;
   assign v      = v_q;
   assign s      = result_q[WIDTH-1];
   assign n      = result_q[WIDTH-1];
   assign z      = (result_q == '0);

endmodule
